// File: rtl/chan_fifo_sched.sv
// -----------------------------------------------------------------------------
// chan_fifo_sched
//
// Takes one sample set, spread across up to 8 channels, and writes it into a
// downstream FIFO as a frame. Each frame is a burst of one-word writes in
// channel order 0..last. The word for the current channel comes from an
// external mux that this block steers with 'sel'. A frame can be stalled at
// any point by fifo_full, and no word is lost when that happens. A strobe that
// arrives while a frame is still being written is dropped. Each dropped strobe
// sets a sticky overrun flag and increments a saturating counter.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   reset      : asynchronous active-high reset
//   en         : enables acceptance of new frames (a running frame completes)
//   strobe     : one-cycle pulse, new sample set ready on all channels
//   channels   : active channel count minus 1, latched at frame start
//   din        : muxed channel word, combinational from sel
//   fifo_full  : downstream FIFO cannot accept a write this cycle
//   clr_ovr    : synchronous clear of overrun / ovr_cnt
//   sel        : registered channel select to the external mux
//   wr_en      : registered FIFO write strobe
//   wr_data    : registered FIFO write word
//   wr_first   : frame marker, high with wr_en on the channel-0 word
//   busy       : registered, high while in WRITE
//   overrun    : sticky, a strobe was dropped
//   ovr_cnt    : saturating count of dropped strobes
//   debug      : {overrun, fifo_full, wr_en, busy, 1'b0, sel[2:0]}
// -----------------------------------------------------------------------------
module chan_fifo_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        strobe,
  input  logic [2:0]  channels,
  input  logic [15:0] din,
  input  logic        fifo_full,
  input  logic        clr_ovr,
  output logic [2:0]  sel,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        wr_first,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] ovr_cnt,
  output logic [7:0]  debug
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t      state_reg;
  logic [2:0]  sel_reg;
  logic [2:0]  last_reg;
  logic        wr_en_reg;
  logic [15:0] wr_data_reg;
  logic        wr_first_reg;
  logic        busy_reg;
  logic        overrun_reg;
  logic [15:0] ovr_cnt_reg;

  logic        overrun_next;
  logic [15:0] ovr_cnt_next;

  logic        accept;
  logic        frame_end;
  logic        drop;

  // A strobe counts only while frames are enabled. With en low it is ignored
  // entirely and is never treated as an overrun.
  assign accept = strobe & en;

  // This edge writes the final word of the current frame.
  assign frame_end = (state_reg == WRITE) & ~fifo_full & (sel_reg == last_reg);

  // A strobe on the frame-end edge chains straight into the next frame. A
  // strobe on any other WRITE edge, stalled or not, is dropped.
  assign drop = (state_reg == WRITE) & accept & ~frame_end;

  // Overrun bookkeeping. A drop on the same edge as a clear wins over the
  // clear, so the flag stays set and the counter restarts at 1.
  always_comb begin
    overrun_next = overrun_reg;
    ovr_cnt_next = ovr_cnt_reg;
    if (drop) begin
      overrun_next = 1'b1;
      if (clr_ovr) begin
        ovr_cnt_next = 16'd1;
      end else if (ovr_cnt_reg != 16'hFFFF) begin
        ovr_cnt_next = ovr_cnt_reg + 16'd1;
      end
    end else if (clr_ovr) begin
      overrun_next = 1'b0;
      ovr_cnt_next = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      sel_reg      <= 3'd0;
      last_reg     <= 3'd0;
      wr_en_reg    <= 1'b0;
      wr_data_reg  <= 16'd0;
      wr_first_reg <= 1'b0;
      busy_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
      ovr_cnt_reg  <= 16'd0;
    end else begin
      overrun_reg <= overrun_next;
      ovr_cnt_reg <= ovr_cnt_next;
      case (state_reg)
        IDLE: begin
          wr_en_reg    <= 1'b0;
          wr_first_reg <= 1'b0;
          if (accept) begin
            state_reg <= WRITE;
            busy_reg  <= 1'b1;
            sel_reg   <= 3'd0;
            last_reg  <= channels;
          end
        end
        WRITE: begin
          if (fifo_full) begin
            // Stall: hold sel and state so that the current word is retried.
            wr_en_reg    <= 1'b0;
            wr_first_reg <= 1'b0;
          end else begin
            wr_data_reg  <= din;
            wr_en_reg    <= 1'b1;
            wr_first_reg <= (sel_reg == 3'd0);
            if (sel_reg != last_reg) begin
              sel_reg <= sel_reg + 3'd1;
            end else begin
              sel_reg <= 3'd0;
              if (accept) begin
                // Back-to-back frame: stay in WRITE and take the new count.
                last_reg <= channels;
              end else begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign sel      = sel_reg;
  assign wr_en    = wr_en_reg;
  assign wr_data  = wr_data_reg;
  assign wr_first = wr_first_reg;
  assign busy     = busy_reg;
  assign overrun  = overrun_reg;
  assign ovr_cnt  = ovr_cnt_reg;

  // Debug bus: the select occupies the low bits, then the status flags.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dbg_sel
      assign debug[gi] = sel_reg[gi];
    end
  endgenerate
  assign debug[3] = 1'b0;
  assign debug[4] = busy_reg;
  assign debug[5] = wr_en_reg;
  assign debug[6] = fifo_full;
  assign debug[7] = overrun_reg;

endmodule

// File: doc/chan_fifo_sched.md
CHAN_FIFO_SCHED -- requirements
Module: chan_fifo_sched

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: en  in  1  enables acceptance of new frames.
REQ-004 SHALL have ports: strobe  in  1  one-cycle pulse, new sample set ready on all channels.
REQ-005 SHALL have ports: channels  in  3  active channel count minus 1 (0 -> 1 channel, 7 -> 8 channels).
REQ-006 SHALL have ports: din  in  16  muxed channel word selected by sel, combinational from sel.
REQ-007 SHALL have ports: fifo_full  in  1  downstream FIFO cannot accept a write this cycle.
REQ-008 SHALL have ports: clr_ovr  in  1  synchronous clear of overrun flag and counter.
REQ-009 SHALL have ports: sel  out  3  channel select driven to the channel mux, registered.
REQ-010 SHALL have ports: wr_en  out  1  FIFO write strobe, registered.
REQ-011 SHALL have ports: wr_data  out  16  FIFO write word, registered.
REQ-012 SHALL have ports: wr_first  out  1  high with wr_en when the word is channel 0 (frame marker).
REQ-013 SHALL have ports: busy  out  1  high while state is WRITE.
REQ-014 SHALL have ports: overrun  out  1  sticky, strobe arrived while a frame was in progress.
REQ-015 SHALL have ports: ovr_cnt  out  16  count of dropped strobes, saturating.
REQ-016 SHALL have ports: debug  out  8  {overrun, fifo_full, wr_en, busy, 1'b0, sel[2:0]}.

Function
REQ-017 SHALL implement two states: IDLE and WRITE.
REQ-018 In IDLE, strobe=1 and en=1 at an edge SHALL move to WRITE, set sel to 0, and latch channels into last; otherwise IDLE SHALL hold.
REQ-019 In WRITE with fifo_full=0 at an edge, SHALL set wr_data<=din, wr_en<=1, and wr_first<=(sel==0).
REQ-020 Under REQ-019, if sel!=last, SHALL increment sel.
REQ-021 Under REQ-019, if sel==last, SHALL set sel to 0 and return to IDLE.
REQ-022 In WRITE with fifo_full=1 at an edge, SHALL set wr_en<=0 and wr_first<=0 and hold sel and state (stall, no data loss).
REQ-023 In IDLE, wr_en and wr_first SHALL be 0 on every edge.
REQ-024 Latency: strobe sampled at edge k with no stall SHALL give the channel-0 word on wr_data with wr_en=1 after edge k+1, and the last word after edge k+N (N=last+1).
REQ-025 A frame SHALL be N consecutive wr_en pulses when fifo_full stays low; words SHALL be in channel order 0..last.
REQ-026 Changes on channels during WRITE SHALL be ignored until the next frame start.
REQ-027 Back-to-back: strobe=1 and en=1 on the edge that writes word last SHALL start a new frame (stay WRITE, sel<=0, relatch last) with no overrun.
REQ-028 Strobe=1 in WRITE on any other edge, including during a stall, SHALL be dropped, set overrun, and increment ovr_cnt.
REQ-029 ovr_cnt SHALL saturate at 0xFFFF.
REQ-030 clr_ovr=1 SHALL clear overrun and ovr_cnt at the edge.
REQ-031 clr_ovr=1 coinciding with a drop event SHALL give overrun=1 and ovr_cnt=1.
REQ-032 en deasserted during WRITE SHALL let the current frame complete.
REQ-033 Strobes with en=0 SHALL be ignored and SHALL NOT count as overrun.
REQ-034 busy SHALL equal (state==WRITE), registered.

Reset
REQ-035 reset=1 SHALL asynchronously force: state IDLE, sel=0, last=0, wr_en=0, wr_first=0, wr_data=0, overrun=0, ovr_cnt=0, busy=0.
REQ-036 Reset mid-frame SHALL abandon the frame; no further wr_en until a new accepted strobe after reset release.
REQ-037 The first edge after release SHALL behave as IDLE.

Verification
REQ-038 channels=3, en=1, din=0x1000+sel, strobe at edge k, fifo_full=0 -> wr_en high after edges k+1..k+4 with wr_data 0x1000,0x1001,0x1002,0x1003, wr_first only on 0x1000, then IDLE.
REQ-039 channels=7, fifo_full=1 for 3 cycles after the 2nd word -> wr_en low 3 cycles, sel holds at 2, all 8 words delivered in order, no loss.
REQ-040 channels=1, strobe on the edge writing word 1 -> next frame starts immediately, overrun=0; strobe one edge earlier instead -> overrun=1, ovr_cnt=1.
REQ-041 Force ovr_cnt to 0xFFFF via repeated drops, another drop -> stays 0xFFFF; clr_ovr with a simultaneous drop -> ovr_cnt=1, overrun=1.
REQ-042 Assert reset mid-frame at sel=2 (between edges) -> all outputs 0 immediately, no wr_en after release until a new strobe.
REQ-043 en=0 with strobes -> no writes, overrun=0; en dropped mid-frame with channels=3 -> all 4 words still written.
